// File: rtl/prioresolve_if.sv
// Handshake bundle between the confirm stage, the priority resolver and the result consumer.
// Field widths follow the rule-ID, priority and counter parameters.
interface prioresolve_if #(
  parameter int unsigned IDWID  = 8,
  parameter int unsigned PRIOR  = 8,
  parameter int unsigned CNTWID = 8
);
  localparam int unsigned CFWID = 1 + IDWID + PRIOR;

  logic [CFWID-1:0]  i_Confirm_Result;
  logic              i_Valid;
  logic              i_Last;
  logic              i_Ready;
  logic              o_Valid;
  logic              o_Hit;
  logic [IDWID-1:0]  o_Rule_ID;
  logic [PRIOR-1:0]  o_Priority;
  logic [CNTWID-1:0] o_Cand_Cnt;
  logic [CNTWID-1:0] o_Drop_Cnt;

  modport slave (
    input  i_Confirm_Result, i_Valid, i_Last, i_Ready,
    output o_Valid, o_Hit, o_Rule_ID, o_Priority, o_Cand_Cnt, o_Drop_Cnt
  );

  modport master (
    output i_Confirm_Result, i_Valid, i_Last, i_Ready,
    input  o_Valid, o_Hit, o_Rule_ID, o_Priority, o_Cand_Cnt, o_Drop_Cnt
  );
endinterface

// File: rtl/prioresolve.sv
// Resolves a group of confirm results for one search key to the winning rule and queues
// the lookup result in a 2-entry output buffer with valid/ready handshake.
module prioresolve #(
  parameter int unsigned IDWID  = 8,
  parameter int unsigned PRIOR  = 8,
  parameter int unsigned CNTWID = 8
) (
  input  logic         clk,
  input  logic         rst,
  prioresolve_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StAcc} state_e;

  typedef struct packed {
    logic              hit;
    logic [IDWID-1:0]  id;
    logic [PRIOR-1:0]  prio;
    logic [CNTWID-1:0] cnt;
  } res_t;

  state_e state_q, state_d;
  res_t   acc_q, acc_d, base, merged;
  res_t   ent0_q, ent0_d, ent1_q, ent1_d, head;
  logic [1:0]        qcnt_q, qcnt_d;
  logic [CNTWID-1:0] drop_q, drop_d;
  logic load, merge, close, pop, take;

  logic             beat_match;
  logic [IDWID-1:0] beat_id;
  logic [PRIOR-1:0] beat_prio;

  assign {beat_match, beat_id, beat_prio} = bus.i_Confirm_Result;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus.i_Valid && !bus.i_Last) state_d = StAcc;
      StAcc:  if (bus.i_Valid && bus.i_Last)  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: control outputs
  always_comb begin
    load  = 1'b0;
    merge = 1'b0;
    close = 1'b0;
    unique case (state_q)
      StIdle: begin
        load  = bus.i_Valid;
        close = bus.i_Valid && bus.i_Last;
      end
      StAcc: begin
        merge = bus.i_Valid;
        close = bus.i_Valid && bus.i_Last;
      end
      default: ;
    endcase
  end

  // A load is a merge into an empty accumulator, so both share one datapath.
  always_comb begin
    base = merge ? acc_q : '0;
    take = beat_match && (!base.hit || (beat_prio > base.prio) ||
                          ((beat_prio == base.prio) && (beat_id < base.id)));
    merged      = base;
    merged.hit  = base.hit | beat_match;
    merged.cnt  = (&base.cnt) ? base.cnt : base.cnt + CNTWID'(1);
    if (take) begin
      merged.id   = beat_id;
      merged.prio = beat_prio;
    end
  end

  always_comb begin
    acc_d = acc_q;
    if (load || merge) acc_d = merged;
  end

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign pop = (qcnt_q != 2'd0) && bus.i_Ready;

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    qcnt_d = qcnt_q;
    drop_d = drop_q;
    case (qcnt_q)
      2'd0: begin
        if (close) begin
          ent0_d = merged;
          qcnt_d = 2'd1;
        end
      end
      2'd1: begin
        if (pop && close)  ent0_d = merged;
        else if (pop)      qcnt_d = 2'd0;
        else if (close) begin
          ent1_d = merged;
          qcnt_d = 2'd2;
        end
      end
      2'd2: begin
        if (pop) begin
          ent0_d = ent1_q;
          if (close) ent1_d = merged;
          else       qcnt_d = 2'd1;
        end else if (close && !(&drop_q)) begin
          drop_d = drop_q + CNTWID'(1);
        end
      end
      default: qcnt_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent0_q <= '0;
      ent1_q <= '0;
      qcnt_q <= 2'd0;
      drop_q <= '0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      qcnt_q <= qcnt_d;
      drop_q <= drop_d;
    end
  end

  assign head           = (qcnt_q != 2'd0) ? ent0_q : '0;
  assign bus.o_Valid    = (qcnt_q != 2'd0);
  assign bus.o_Hit      = head.hit;
  assign bus.o_Rule_ID  = head.id;
  assign bus.o_Priority = head.prio;
  assign bus.o_Cand_Cnt = head.cnt;
  assign bus.o_Drop_Cnt = drop_q;

endmodule

// File: tb/tb_prioresolve.sv
// Randomized and directed bench for prioresolve, checked every cycle against a
// behavioural model that keeps whole candidate groups and the result queue as lists.
module tb_prioresolve;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prioresolve_if bus ();
  prioresolve dut (.clk(clk), .rst(rst), .bus(bus));

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  logic [16:0] grp[$];
  logic [24:0] outq[$];
  int          drops = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Winner is the matched beat with the largest {priority, inverted id} key.
  function automatic logic [24:0] resolve();
    logic        hit = 1'b0;
    logic [15:0] key = '0;
    logic [15:0] k;
    logic [7:0]  n;
    n = (grp.size() > 255) ? 8'd255 : 8'(grp.size());
    foreach (grp[i]) begin
      if (grp[i][16]) begin
        k = {grp[i][7:0], ~grp[i][15:8]};
        if (!hit || k > key) key = k;
        hit = 1'b1;
      end
    end
    if (hit) return {1'b1, ~key[7:0], key[15:8], n};
    return {1'b0, 16'h0, n};
  endfunction

  task automatic model_step(input bit v, input bit l, input logic [16:0] cr,
                            input bit rdy, input bit r);
    int          sz;
    bit          popped;
    logic [24:0] res;
    if (r) begin
      grp.delete();
      outq.delete();
      drops = 0;
      return;
    end
    sz     = outq.size();
    popped = (sz > 0) && rdy;
    if (v) grp.push_back(cr);
    if (popped) void'(outq.pop_front());
    if (v && l) begin
      res = resolve();
      grp.delete();
      if (sz == 2 && !popped) begin
        if (drops < 255) drops++;
      end else begin
        outq.push_back(res);
      end
    end
  endtask

  always @(negedge clk) begin
    logic [24:0] h;
    if (chk_en) begin
      h = (outq.size() > 0) ? outq[0] : 25'h0;
      check("valid", {31'h0, bus.o_Valid}, (outq.size() > 0) ? 32'h1 : 32'h0);
      check("hit",   {31'h0, bus.o_Hit}, {31'h0, h[24]});
      check("id",    {24'h0, bus.o_Rule_ID}, {24'h0, h[23:16]});
      check("prio",  {24'h0, bus.o_Priority}, {24'h0, h[15:8]});
      check("cnt",   {24'h0, bus.o_Cand_Cnt}, {24'h0, h[7:0]});
      check("drop",  {24'h0, bus.o_Drop_Cnt}, 32'(drops));
    end
  end

  task automatic step(input bit v, input bit l, input logic [16:0] cr,
                      input bit rdy, input bit r);
    rst                  = r;
    bus.i_Valid          = v;
    bus.i_Last           = l;
    bus.i_Confirm_Result = cr;
    bus.i_Ready          = rdy;
    @(posedge clk);
    model_step(v, l, cr, rdy, r);
    @(negedge clk);
  endtask

  function automatic logic [16:0] beat(input bit m, input logic [7:0] id, input logic [7:0] p);
    return {m, id, p};
  endfunction

  task automatic head_is(input string name, input bit v, input bit h, input logic [7:0] id,
                         input logic [7:0] p, input logic [7:0] c);
    check({name, ".v"},    {31'h0, bus.o_Valid}, {31'h0, v});
    check({name, ".hit"},  {31'h0, bus.o_Hit}, {31'h0, h});
    check({name, ".id"},   {24'h0, bus.o_Rule_ID}, {24'h0, id});
    check({name, ".prio"}, {24'h0, bus.o_Priority}, {24'h0, p});
    check({name, ".cnt"},  {24'h0, bus.o_Cand_Cnt}, {24'h0, c});
  endtask

  initial begin
    rst = 1'b1;
    bus.i_Valid = 1'b0;
    bus.i_Last = 1'b0;
    bus.i_Confirm_Result = '0;
    bus.i_Ready = 1'b0;
    @(negedge clk);
    step(0, 0, '0, 0, 1);
    chk_en = 1'b1;
    head_is("reset", 0, 0, 8'h00, 8'h00, 8'h00);
    check("reset.drop", {24'h0, bus.o_Drop_Cnt}, 32'h0);

    // Single beat
    step(1, 1, beat(1, 8'h12, 8'h40), 1, 0);
    head_is("single", 1, 1, 8'h12, 8'h40, 8'h01);
    step(0, 0, '0, 1, 0);
    head_is("single_pop", 0, 0, 8'h00, 8'h00, 8'h00);

    // Three beats, unmatched high priority ignored
    step(1, 0, beat(1, 8'h05, 8'h10), 1, 0);
    step(1, 0, beat(0, 8'h22, 8'hFF), 1, 0);
    step(0, 1, beat(1, 8'h77, 8'hFE), 1, 0);
    step(1, 1, beat(1, 8'h09, 8'h30), 1, 0);
    head_is("group3", 1, 1, 8'h09, 8'h30, 8'h03);
    step(0, 0, '0, 1, 0);

    // Tie on priority goes to lower id; all-unmatched group
    step(1, 0, beat(1, 8'h20, 8'h50), 1, 0);
    step(1, 1, beat(1, 8'h07, 8'h50), 1, 0);
    head_is("tie", 1, 1, 8'h07, 8'h50, 8'h02);
    step(1, 0, beat(0, 8'h31, 8'h60), 1, 0);
    step(1, 1, beat(0, 8'h32, 8'h70), 1, 0);
    head_is("nomatch", 1, 0, 8'h00, 8'h00, 8'h02);
    step(0, 0, '0, 1, 0);

    // Full queue with ready low: third result dropped
    step(1, 1, beat(1, 8'h01, 8'h01), 0, 0);
    step(1, 1, beat(1, 8'h02, 8'h01), 0, 0);
    step(1, 1, beat(1, 8'h03, 8'h01), 0, 0);
    head_is("full", 1, 1, 8'h01, 8'h01, 8'h01);
    check("full.drop", {24'h0, bus.o_Drop_Cnt}, 32'h1);
    step(0, 0, '0, 1, 0);
    head_is("drain1", 1, 1, 8'h02, 8'h01, 8'h01);
    step(0, 0, '0, 1, 0);
    head_is("drain2", 0, 0, 8'h00, 8'h00, 8'h00);

    // Full queue, pop and push together: no drop
    step(1, 1, beat(1, 8'h04, 8'h02), 0, 0);
    step(1, 1, beat(1, 8'h05, 8'h02), 0, 0);
    step(1, 1, beat(1, 8'h06, 8'h02), 1, 0);
    head_is("pp", 1, 1, 8'h05, 8'h02, 8'h01);
    check("pp.drop", {24'h0, bus.o_Drop_Cnt}, 32'h1);
    step(0, 0, '0, 1, 0);
    head_is("pp2", 1, 1, 8'h06, 8'h02, 8'h01);
    step(0, 0, '0, 1, 0);

    // Reset mid-group clears everything
    step(1, 1, beat(1, 8'h0A, 8'h0A), 0, 0);
    step(1, 0, beat(1, 8'hAA, 8'hF0), 0, 0);
    step(1, 0, beat(1, 8'hAB, 8'hF0), 0, 0);
    step(1, 0, beat(1, 8'hAC, 8'hF0), 0, 1);
    head_is("rst", 0, 0, 8'h00, 8'h00, 8'h00);
    check("rst.drop", {24'h0, bus.o_Drop_Cnt}, 32'h0);
    step(1, 1, beat(1, 8'h33, 8'h01), 1, 0);
    head_is("post_rst", 1, 1, 8'h33, 8'h01, 8'h01);
    step(0, 0, '0, 1, 0);

    // Candidate count saturation
    for (int i = 0; i < 300; i++) begin
      if (i == 150) step(1, 0, beat(1, 8'h44, 8'h80), 1, 0);
      else          step(1, i == 299, beat(1, 8'(i), 8'h10), 1, 0);
    end
    head_is("cnt_sat", 1, 1, 8'h44, 8'h80, 8'hFF);
    step(0, 0, '0, 1, 0);

    // Drop count saturation
    for (int i = 0; i < 262; i++) step(1, 1, beat(0, 8'(i), 8'h00), 0, 0);
    check("drop_sat", {24'h0, bus.o_Drop_Cnt}, 32'hFF);
    step(0, 0, '0, 1, 0);
    step(0, 0, '0, 1, 0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      bit          r, v, l, rdy;
      logic [16:0] cr;
      r   = ($urandom_range(0, 299) == 0);
      v   = ($urandom_range(0, 3) != 0);
      l   = ($urandom_range(0, 2) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      cr  = {1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)),
             ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 3)) : 8'($urandom)};
      step(v, l, cr, rdy, r);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/prioresolve.md
# prioresolve

Downstream of the confirmation-memory stage. Collects the per-candidate confirm results produced for one search key. A key can yield several candidate rule IDs. The block resolves the group to one winning rule by priority and queues the final lookup result in a 2-entry buffer with valid/ready output handshake. It is the last stage of the TCAM lookup pipeline, and its output goes to the host/result interface.

## Interface
- IDWID, 8, rule ID width
- PRIOR, 8, rule priority width
- CFWID, 1+IDWID+PRIOR (17), confirm result width; layout {match, rule ID, priority}
- CNTWID, 8, width of candidate and drop counters
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- i_Confirm_Result  in  CFWID  [CFWID-1]=match, [CFWID-2:PRIOR]=rule ID, [PRIOR-1:0]=priority
- i_Valid  in  1  candidate beat present this cycle; upstream cannot stall
- i_Last  in  1  qualifies i_Valid; final candidate of the current key
- o_Valid  out  1  output queue head valid
- i_Ready  in  1  consumer accepts head when o_Valid && i_Ready
- o_Hit  out  1  at least one candidate in the group matched
- o_Rule_ID  out  IDWID  winning rule ID; 0 when o_Hit=0
- o_Priority  out  PRIOR  winning priority; 0 when o_Hit=0
- o_Cand_Cnt  out  CNTWID  beats in group, saturating at all-ones
- o_Drop_Cnt  out  CNTWID  results lost to full queue, saturating

## Operation
- FSM states:
  - IDLE: no group open.
  - ACC: group open.
- IDLE transitions:
  - i_Valid && !i_Last: load accumulator from the beat, go to ACC.
  - i_Valid && i_Last: single-beat group; close immediately, stay IDLE.
- ACC transitions:
  - i_Valid && !i_Last: merge the beat into the accumulator.
  - i_Valid && i_Last: merge the beat, close the group, go to IDLE.
  - !i_Valid: hold; gaps inside a group are legal.
- Accumulator holds best_hit, best_id, best_prio and cnt. On load, cnt=1 and best_* are taken from the beat only if match=1; otherwise best_* are cleared.
- Merge rule: a beat with match=0 only increments cnt. A beat with match=1 replaces the best when either:
  - best_hit=0, or
  - prio > best_prio, or
  - prio == best_prio and id < best_id.
- Larger priority value wins; ties go to the lower rule ID.
- Close builds the result word {hit, id, prio, cnt} from the merged value that includes the closing beat. The accumulator is not read back later.
- Output queue is 2 entries deep with registered head and tail. Push happens on close; pop happens on o_Valid && i_Ready.
- Push while the queue holds 2 entries and no pop this cycle: result is dropped, o_Drop_Cnt increments (saturating), queue is unchanged.
- Push and pop in the same cycle while full: push is accepted and the queue stays at 2.
- cnt saturates at 2^CNTWID-1. Priority comparison is unsigned.

## Timing
- Reset values: state=IDLE, queue empty, o_Valid=0, o_Hit=0, o_Rule_ID=0, o_Priority=0, o_Cand_Cnt=0, o_Drop_Cnt=0. The accumulator is cleared.
- Latency: closing beat sampled at edge N. If the queue was empty, o_Valid=1 with the result fields after edge N (visible in cycle N+1).
- Head fields are stable while o_Valid=1 && i_Ready=0. Fields are 0 when the queue is empty.
- Sustained throughput is one group per cycle (single-beat groups) while i_Ready=1.
- rst asserted mid-group discards the open group and the queued results. rst has priority over all other inputs in the same cycle.
- i_Last with i_Valid=0 is ignored.

## Test plan
- Single beat {1,ID=0x12,P=0x40}, valid+last, i_Ready=1: next cycle o_Valid=1, hit=1, ID=0x12, prio=0x40, cnt=1; o_Valid=0 the cycle after.
- Group of 3 beats {1,0x05,0x10}, {0,0x22,0xFF}, {1,0x09,0x30}(last): result ID=0x09, prio=0x30, cnt=3; the unmatched 0xFF beat is ignored.
- Tie: {1,0x20,0x50} then {1,0x07,0x50}(last): ID=0x07. Group with all match=0 (2 beats): hit=0, ID=0, prio=0, cnt=2.
- i_Ready=0, three single-beat groups closed: first two held in order, third dropped, o_Drop_Cnt=1. Raise i_Ready: results 1 then 2 pop on consecutive cycles.
- Queue full with i_Ready=1 and a close in the same cycle: no drop, o_Drop_Cnt unchanged, results emerge in arrival order.
- rst pulse after 2 beats of an open group: all outputs return to 0. A following single-beat group yields cnt=1 with no residue from the aborted group.
